// File: rtl/dbus_bridge.sv
// dbus_bridge: turns each LSU RAM request into one registered req/ack data-bus transaction and stalls the pipeline until it completes
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   lsu_ce_i/we_i/a_i/sel_i/wd_i  combinational request from the LSU, sampled only in IDLE
//   lsu_rd_o                whole read word, valid only in the DONE cycle (0 otherwise and for stores)
//   stall_req_o             combinational stall to ctrl: (IDLE && lsu_ce_i) || REQ
//   bus_req_o/we_o/a_o/sel_o/wd_o  registered bus request, held stable while waiting for ack
//   bus_ack_i, bus_rd_i     transfer complete, read data valid with ack
//   bus_err_i               error response, terminates like ack and wins over it
//   err_o                   one-cycle pulse in DONE when the access failed
//
// Build option: define DBUS_TIMEOUT_EN to add parameter TIMEOUT_CYCLES and abort a
// transfer that sees no ack or err within TIMEOUT_CYCLES REQ cycles.
module dbus_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef DBUS_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                lsu_ce_i,
   input  logic                lsu_we_i,
   input  logic [ADDR_W-1:0]   lsu_a_i,
   input  logic [DATA_W/8-1:0] lsu_sel_i,
   input  logic [DATA_W-1:0]   lsu_wd_i,
   output logic [DATA_W-1:0]   lsu_rd_o,
   output logic                stall_req_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_a_o,
   output logic [DATA_W/8-1:0] bus_sel_o,
   output logic [DATA_W-1:0]   bus_wd_o,
   input  logic                bus_ack_i,
   input  logic [DATA_W-1:0]   bus_rd_i,
   input  logic                bus_err_i,
   output logic                err_o
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state, state_nxt;
   logic [DATA_W-1:0] data_q;
   logic err_q;
   logic timeout;
   logic abort;
   logic fin;
`ifdef DBUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   // cnt sits at 0 outside REQ, so it is already clear on entry; the abort fires in
   // the cycle whose increment would make the count reach TIMEOUT_CYCLES
   always_ff @(posedge clk_i) begin
      if (rst_i || state != REQ) cnt <= '0;
      else if (!bus_ack_i && !bus_err_i) cnt <= cnt + 1'b1;
   end
   assign timeout = state == REQ && !bus_ack_i && !bus_err_i && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   assign abort = bus_err_i || timeout;
   assign fin = state == REQ && (bus_ack_i || abort);
   always_comb begin
      state_nxt = state;
      stall_req_o = 1'b0;
      lsu_rd_o = '0;
      err_o = err_q;
      case (state)
         IDLE: begin
            stall_req_o = lsu_ce_i;
            state_nxt = lsu_ce_i ? REQ : IDLE;
         end
         REQ: begin
            stall_req_o = 1'b1;
            state_nxt = fin ? DONE : REQ;
         end
         DONE: begin
            lsu_rd_o = data_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         bus_req_o <= 1'b0;
         bus_we_o <= 1'b0;
         bus_a_o <= '0;
         bus_sel_o <= '0;
         bus_wd_o <= '0;
         data_q <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         // err_q is only ever set on the REQ->DONE edge, so it lasts exactly the DONE cycle
         err_q <= fin && abort;
         if (state == IDLE && lsu_ce_i) begin
            bus_req_o <= 1'b1;
            bus_we_o <= lsu_we_i;
            bus_a_o <= lsu_a_i;
            bus_sel_o <= lsu_sel_i;
            bus_wd_o <= lsu_wd_i;
         end
         if (fin) begin
            bus_req_o <= 1'b0;
            data_q <= (abort || bus_we_o) ? '0 : bus_rd_i;
         end
      end
   end
endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: randomized self-checking bench for dbus_bridge against a per-transaction reference model
module tb_dbus_bridge;
   localparam int TO = 4;
   logic clk_i = 1'b0;
   logic rst_i;
   logic lsu_ce_i, lsu_we_i;
   logic [31:0] lsu_a_i, lsu_wd_i, lsu_rd_o;
   logic [3:0] lsu_sel_i;
   logic stall_req_o, bus_req_o, bus_we_o, bus_ack_i, bus_err_i, err_o;
   logic [31:0] bus_a_o, bus_wd_o, bus_rd_i;
   logic [3:0] bus_sel_o;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk_i = ~clk_i;
   dbus_bridge #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef DBUS_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .lsu_ce_i(lsu_ce_i),
      .lsu_we_i(lsu_we_i),
      .lsu_a_i(lsu_a_i),
      .lsu_sel_i(lsu_sel_i),
      .lsu_wd_i(lsu_wd_i),
      .lsu_rd_o(lsu_rd_o),
      .stall_req_o(stall_req_o),
      .bus_req_o(bus_req_o),
      .bus_we_o(bus_we_o),
      .bus_a_o(bus_a_o),
      .bus_sel_o(bus_sel_o),
      .bus_wd_o(bus_wd_o),
      .bus_ack_i(bus_ack_i),
      .bus_rd_i(bus_rd_i),
      .bus_err_i(bus_err_i),
      .err_o(err_o)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic idle_gap();
      @(negedge clk_i);
      lsu_ce_i = 1'b0;
      lsu_a_i = $urandom;
      bus_ack_i = 1'($urandom);
      bus_err_i = 1'($urandom);
      #1;
      check("gap_stall", stall_req_o, 0);
      check("gap_req", bus_req_o, 0);
      check("gap_err", err_o, 0);
      check("gap_rd", lsu_rd_o, 0);
   endtask
   // One access: the reply (ack, err, or both) arrives after `waits` extra REQ cycles.
   // Expected behaviour comes from the access rules: the request fields hold for every
   // REQ cycle, stall covers IDLE plus all REQ cycles, DONE returns the load word or 0.
   task automatic txn(input logic we, input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic err, input logic both);
      int eff;
      logic to, xerr;
      logic [31:0] xrd;
      eff = waits;
      to = 1'b0;
`ifdef DBUS_TIMEOUT_EN
      if (waits >= TO) begin
         eff = TO - 1;
         to = 1'b1;
      end
`endif
      xerr = err || to;
      xrd = (xerr || we) ? 32'h0 : rd;
      @(negedge clk_i);
      lsu_ce_i = 1'b1;
      lsu_we_i = we;
      lsu_a_i = a;
      lsu_sel_i = sel;
      lsu_wd_i = wd;
      bus_ack_i = 1'($urandom);
      bus_err_i = 1'($urandom);
      #1;
      check("idle_stall", stall_req_o, 1);
      check("idle_req", bus_req_o, 0);
      check("idle_rd", lsu_rd_o, 0);
      check("idle_err", err_o, 0);
      for (int w = 0; w <= eff; w++) begin
         @(negedge clk_i);
         lsu_ce_i = 1'($urandom);
         lsu_we_i = 1'($urandom);
         lsu_a_i = $urandom;
         lsu_sel_i = 4'($urandom);
         lsu_wd_i = $urandom;
         bus_rd_i = (w == waits) ? rd : $urandom;
         bus_ack_i = (w == waits) && (!err || both);
         bus_err_i = (w == waits) && err;
         #1;
         check("req_req", bus_req_o, 1);
         check("req_we", bus_we_o, we);
         check("req_a", bus_a_o, a);
         check("req_sel", bus_sel_o, sel);
         check("req_wd", bus_wd_o, wd);
         check("req_stall", stall_req_o, 1);
         check("req_rd", lsu_rd_o, 0);
         check("req_err", err_o, 0);
      end
      @(negedge clk_i);
      bus_ack_i = 1'($urandom);
      bus_err_i = 1'($urandom);
      bus_rd_i = $urandom;
      lsu_ce_i = 1'($urandom);
      #1;
      check("done_req", bus_req_o, 0);
      check("done_stall", stall_req_o, 0);
      check("done_rd", lsu_rd_o, xrd);
      check("done_err", err_o, xerr);
   endtask
   initial begin
      rst_i = 1'b1;
      lsu_ce_i = 1'b0;
      lsu_we_i = 1'b0;
      lsu_a_i = '0;
      lsu_sel_i = '0;
      lsu_wd_i = '0;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      bus_rd_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_req", bus_req_o, 0);
      check("rst_stall", stall_req_o, 0);
      check("rst_a", bus_a_o, 0);
      check("rst_wd", bus_wd_o, 0);
      check("rst_err", err_o, 0);
      check("rst_rd", lsu_rd_o, 0);
      rst_i = 1'b0;
      idle_gap();
      txn(1'b0, 32'h100, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
      txn(1'b1, 32'h204, 4'b0011, 32'h12341234, 3, 32'h55AA55AA, 1'b0, 1'b0);
      idle_gap();
      txn(1'b0, 32'h300, 4'hF, 32'h0, 1, 32'hCAFEF00D, 1'b0, 1'b0);
      txn(1'b1, 32'h304, 4'hC, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b0);
      txn(1'b0, 32'h400, 4'hF, 32'h0, 0, 32'hFFFFFFFF, 1'b1, 1'b1);
      idle_gap();
      // reset two cycles into REQ, then a stray ack
      @(negedge clk_i);
      lsu_ce_i = 1'b1;
      lsu_we_i = 1'b0;
      lsu_a_i = 32'h500;
      lsu_sel_i = 4'hF;
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      repeat (2) begin
         @(negedge clk_i);
         lsu_ce_i = 1'b0;
         #1;
         check("rstreq_req", bus_req_o, 1);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      bus_ack_i = 1'b1;
      bus_rd_i = 32'h13579BDF;
      #1;
      check("rstreq_req0", bus_req_o, 0);
      check("rstreq_stall", stall_req_o, 0);
      check("rstreq_err", err_o, 0);
      check("rstreq_a", bus_a_o, 0);
      @(negedge clk_i);
      bus_ack_i = 1'b0;
      #1;
      check("stray_req", bus_req_o, 0);
      check("stray_err", err_o, 0);
      check("stray_rd", lsu_rd_o, 0);
      check("stray_stall", stall_req_o, 0);
      // no reply for a long time: timeout abort when built in, otherwise a long stall ended by err
      txn(1'b0, 32'h600, 4'hF, 32'h0, 120, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) idle_gap();
         txn(1'($urandom), $urandom, 4'($urandom), $urandom, int'($urandom_range(0, 6)), $urandom,
             $urandom_range(0, 4) == 0, 1'($urandom));
      end
      idle_gap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
